// File: rtl/avl_uart_slave_if.sv
// Avalon-MM pipelined bus bundle between the interconnect's uart_* master and the UART slave.
interface avl_uart_slave_if;
    logic [4:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        burstcount;
    logic        debugaccess;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (output address, read, write, writedata, byteenable, burstcount, debugaccess,
                    input  waitrequest, readdata, readdatavalid);
    modport slave  (input  address, read, write, writedata, byteenable, burstcount, debugaccess,
                    output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/avl_uart_slave.sv
// 8N1 UART with TX/RX FIFOs, sticky status flags and a programmable baud divisor,
// exposed as an Avalon-MM slave with fixed read latency of one clock.
module avl_uart_slave #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 433
) (
    input  logic            clk,
    input  logic            rst,
    avl_uart_slave_if.slave bus,
    output logic            uart_txd,
    input  logic            uart_rxd,
    output logic            irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_e;

    tx_state_e        tx_state_q;
    rx_state_e        rx_state_q;
    logic [DIV_W-1:0] div_q, div_d, tx_cnt_q, rx_cnt_q, rx_half;
    logic [2:0]       tx_bit_q, rx_bit_q, sel;
    logic [7:0]       tx_sh_q, rx_sh_q, tx_rdata, rx_rdata, status;
    logic             txd_q, rx_s1_q, rx_s2_q, rx_s3_q;
    logic             tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, frm_err_q, frm_err_d;
    logic             irq_q, irq_d, rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [AW:0]      tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [7:0]       tx_mem_q [FIFO_DEPTH];
    logic [7:0]       rx_mem_q [FIFO_DEPTH];
    logic             tx_empty, tx_full, rx_empty, rx_full, tx_busy;
    logic             wr_data, tx_push, tx_pop, rx_push, rx_pop, rx_done, rx_bad;
    logic             unused_ok;

    assign sel      = bus.address[4:2];
    assign tx_empty = tx_wp_q == tx_rp_q;
    assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign rx_empty = rx_wp_q == rx_rp_q;
    assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign tx_rdata = tx_mem_q[tx_rp_q[AW-1:0]];
    assign rx_rdata = rx_mem_q[rx_rp_q[AW-1:0]];
    assign tx_busy  = tx_state_q != S_IDLE;
    assign status   = {tx_busy, tx_ovf_q, frm_err_q, rx_ovr_q, rx_full, rx_empty, tx_empty, tx_full};

    // A full FIFO still accepts a push when the same cycle pops it.
    assign wr_data = bus.write && sel == 3'd0 && bus.byteenable[0];
    assign tx_pop  = !tx_empty && (tx_state_q == S_IDLE || (tx_state_q == S_STOP && tx_cnt_q == '0));
    assign tx_push = wr_data && (!tx_full || tx_pop);
    assign rx_pop  = bus.read && sel == 3'd0 && !rx_empty;
    assign rx_done = rx_state_q == R_STOP && rx_cnt_q == '0 && rx_s2_q;
    assign rx_bad  = rx_state_q == R_STOP && rx_cnt_q == '0 && !rx_s2_q;
    assign rx_push = rx_done && (!rx_full || rx_pop);
    assign rx_half = (div_q == '0) ? '0 : (div_q - DIV_W'(1)) >> 1;

    assign bus.waitrequest   = 1'b0;
    assign bus.readdata      = rdata_q;
    assign bus.readdatavalid = rvalid_q;
    assign uart_txd          = txd_q;
    assign irq               = irq_q;
    assign unused_ok = ^{bus.address[1:0], bus.writedata, bus.byteenable, bus.burstcount, bus.debugaccess};

    always_comb begin
        div_d     = div_q;
        tx_ovf_d  = tx_ovf_q;
        rx_ovr_d  = rx_ovr_q;
        frm_err_d = frm_err_q;
        rdata_d   = rdata_q;
        rvalid_d  = bus.read;
        tx_wp_d   = tx_wp_q + (AW+1)'(tx_push);
        tx_rp_d   = tx_rp_q + (AW+1)'(tx_pop);
        rx_wp_d   = rx_wp_q + (AW+1)'(rx_push);
        rx_rp_d   = rx_rp_q + (AW+1)'(rx_pop);
        // Read decode uses pre-write state, so a same-cycle write is not visible.
        if (bus.read) begin
            case (sel)
                3'd0:    rdata_d = rx_empty ? 32'h0 : {23'h0, 1'b1, rx_rdata};
                3'd1:    rdata_d = {24'h0, status};
                3'd2:    rdata_d = 32'(div_q);
                default: rdata_d = 32'h0;
            endcase
        end
        if (bus.write && sel == 3'd2) begin
            for (int i = 0; i < DIV_W; i++)
                if (bus.byteenable[i/8]) div_d[i] = bus.writedata[i];
        end
        if (bus.write && sel == 3'd1) begin
            if (bus.writedata[4]) rx_ovr_d  = 1'b0;
            if (bus.writedata[5]) frm_err_d = 1'b0;
            if (bus.writedata[6]) tx_ovf_d  = 1'b0;
        end
        if (wr_data && !tx_push) tx_ovf_d  = 1'b1;
        if (rx_done && !rx_push) rx_ovr_d  = 1'b1;
        if (rx_bad)              frm_err_d = 1'b1;
        irq_d = !rx_empty || (tx_empty && tx_state_q == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= DIV_W'(DEFAULT_DIV);
            tx_ovf_q  <= 1'b0;
            rx_ovr_q  <= 1'b0;
            frm_err_q <= 1'b0;
            rdata_q   <= 32'h0;
            rvalid_q  <= 1'b0;
            irq_q     <= 1'b0;
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
        end else begin
            div_q     <= div_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_ovr_q  <= rx_ovr_d;
            frm_err_q <= frm_err_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            irq_q     <= irq_d;
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= bus.writedata[7:0];
        if (rx_push) rx_mem_q[rx_wp_q[AW-1:0]] <= rx_sh_q;
    end

    // Bit timers count down from the divisor, so a new DIV lands at the next bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                S_IDLE: if (tx_pop) begin
                    tx_state_q <= S_START;
                    tx_sh_q    <= tx_rdata;
                    tx_cnt_q   <= div_q;
                    txd_q      <= 1'b0;
                end
                S_START: if (tx_cnt_q == '0) begin
                    tx_state_q <= S_DATA;
                    tx_cnt_q   <= div_q;
                    tx_bit_q   <= '0;
                    txd_q      <= tx_sh_q[0];
                end else tx_cnt_q <= tx_cnt_q - DIV_W'(1);
                S_DATA: if (tx_cnt_q == '0) begin
                    tx_cnt_q <= div_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_q <= S_STOP;
                        txd_q      <= 1'b1;
                    end else begin
                        tx_bit_q <= tx_bit_q + 3'd1;
                        tx_sh_q  <= tx_sh_q >> 1;
                        txd_q    <= tx_sh_q[1];
                    end
                end else tx_cnt_q <= tx_cnt_q - DIV_W'(1);
                S_STOP: if (tx_cnt_q == '0) begin
                    if (tx_pop) begin
                        tx_state_q <= S_START;
                        tx_sh_q    <= tx_rdata;
                        tx_cnt_q   <= div_q;
                        txd_q      <= 1'b0;
                    end else tx_state_q <= S_IDLE;
                end else tx_cnt_q <= tx_cnt_q - DIV_W'(1);
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rx_s1_q <= uart_rxd;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
            case (rx_state_q)
                R_IDLE: if (rx_s3_q && !rx_s2_q) begin
                    rx_state_q <= R_START;
                    rx_cnt_q   <= rx_half;
                end
                R_START: if (rx_cnt_q == '0) begin
                    rx_state_q <= rx_s2_q ? R_IDLE : R_DATA;
                    rx_cnt_q   <= div_q;
                    rx_bit_q   <= '0;
                end else rx_cnt_q <= rx_cnt_q - DIV_W'(1);
                R_DATA: if (rx_cnt_q == '0) begin
                    rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_q <= div_q;
                    if (rx_bit_q == 3'd7) rx_state_q <= R_STOP;
                    else                  rx_bit_q   <= rx_bit_q + 3'd1;
                end else rx_cnt_q <= rx_cnt_q - DIV_W'(1);
                R_STOP: if (rx_cnt_q == '0) rx_state_q <= rx_s2_q ? R_IDLE : R_BREAK;
                        else                rx_cnt_q   <= rx_cnt_q - DIV_W'(1);
                R_BREAK: if (rx_s2_q) rx_state_q <= R_IDLE;
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avl_uart_slave.sv
// Directed bench for avl_uart_slave: register access, TX waveform, RX framing, FIFO limits, reset.
module tb_avl_uart_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_txd, uart_rxd, irq;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] d;
    logic        v;

    avl_uart_slave_if bus ();

    avl_uart_slave #(.FIFO_DEPTH(16), .DIV_W(16), .DEFAULT_DIV(433)) dut (
        .clk(clk), .rst(rst), .bus(bus), .uart_txd(uart_txd), .uart_rxd(uart_rxd), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        bus.address = a; bus.writedata = wd; bus.byteenable = be; bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] rd, output logic rv);
        @(negedge clk);
        bus.address = a; bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
        rv = bus.readdatavalid;
        rd = bus.readdata;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rxd = f[k];
            repeat (8) @(negedge clk);
        end
        uart_rxd = 1'b1;
    endtask

    // Expected txd per clock at DIV=3: start, 8 data bits LSB first, stop; 4 clocks each.
    function automatic logic [39:0] frame_wave(input logic [7:0] b);
        logic [39:0] w;
        for (int k = 0; k < 40; k++)
            w[k] = (k < 4) ? 1'b0 : (k < 36) ? b[(k-4)/4] : 1'b1;
        return w;
    endfunction

    task automatic test_reset;
        bus.address = '0; bus.read = 0; bus.write = 0; bus.writedata = '0;
        bus.byteenable = '0; bus.burstcount = 1'b1; bus.debugaccess = 1'b0;
        uart_rxd = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({uart_txd, bus.readdatavalid, irq, bus.waitrequest} !== 4'b1000 || bus.readdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got txd/rv/irq/wr=%b rdata=%h, want 1000 rdata=00000000",
                     {uart_txd, bus.readdatavalid, irq, bus.waitrequest}, bus.readdata);
        end
        rst = 1'b0;
        bus_rd(5'h04, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 32'h6) begin
            n_err++; $display("FAIL reset_status: got v=%b d=%h, want v=1 d=00000006", v, d);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h6) begin
            n_err++;
            $display("FAIL rvalid_pulse: got v=%b d=%h, want v=0 d=00000006", bus.readdatavalid, bus.readdata);
        end
        bus_rd(5'h08, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 32'd433) begin
            n_err++; $display("FAIL reset_div: got %0d, want 433", d);
        end
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL irq_idle: got %b, want 1", irq);
        end
    endtask

    task automatic test_tx_frame;
        logic [39:0] o;
        bit found;
        bus_wr(5'h08, 32'd3, 4'h3);
        bus_wr(5'h00, 32'hA5, 4'h1);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (uart_txd === 1'b0) found = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL tx_start_timeout: got txd=%b, want 0 within 10 clocks", uart_txd);
        end else begin
            o[0] = uart_txd;
            for (int k = 1; k < 40; k++) begin @(negedge clk); o[k] = uart_txd; end
            n_cmp++;
            if (o !== frame_wave(8'hA5)) begin
                n_err++; $display("FAIL tx_wave_a5: got %h, want %h", o, frame_wave(8'hA5));
            end
        end
        bus_rd(5'h04, d, v);
        n_cmp++;
        if (d !== 32'h6) begin
            n_err++; $display("FAIL tx_done_status: got %h, want 00000006", d);
        end
    endtask

    task automatic test_back_to_back;
        logic obs [680];
        logic [39:0] fw;
        logic [31:0] sd;
        logic sv;
        bit found;
        logic idle_ok;
        bus_wr(5'h08, 32'd3, 4'h3);
        found = 0;
        fork
            begin
                @(negedge clk);
                bus.address = 5'h00; bus.byteenable = 4'h1; bus.write = 1'b1;
                for (int i = 0; i < 18; i++) begin
                    bus.writedata = 32'h10 + 32'(i);
                    @(negedge clk);
                end
                bus.write = 1'b0;
                bus_rd(5'h04, sd, sv);
            end
            begin
                for (int k = 0; k < 10 && !found; k++) begin
                    @(negedge clk);
                    if (uart_txd === 1'b0) found = 1;
                end
                if (found) begin
                    obs[0] = 1'b0;
                    for (int k = 1; k < 680; k++) begin @(negedge clk); obs[k] = uart_txd; end
                end
            end
        join
        n_cmp++;
        if (sd !== 32'hC5) begin
            n_err++; $display("FAIL b2b_full_ovf_status: got %h, want 000000c5", sd);
        end
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL b2b_start_timeout: got no start bit, want start within 10 clocks");
        end else begin
            for (int f = 0; f < 17; f++) begin
                for (int k = 0; k < 40; k++) fw[k] = obs[f*40 + k];
                n_cmp++;
                if (fw !== frame_wave(8'h10 + 8'(f))) begin
                    n_err++; $display("FAIL b2b_frame%0d: got %h, want %h", f, fw, frame_wave(8'h10 + 8'(f)));
                end
            end
        end
        idle_ok = 1'b1;
        for (int k = 0; k < 40; k++) begin @(negedge clk); if (uart_txd !== 1'b1) idle_ok = 1'b0; end
        n_cmp++;
        if (idle_ok !== 1'b1) begin
            n_err++; $display("FAIL b2b_dropped_byte_sent: got activity on txd, want idle high");
        end
        bus_rd(5'h04, d, v);
        n_cmp++;
        if (d !== 32'h46) begin
            n_err++; $display("FAIL b2b_after_status: got %h, want 00000046", d);
        end
        bus_wr(5'h04, 32'h40, 4'hF);
        bus_rd(5'h04, d, v);
        n_cmp++;
        if (d !== 32'h06) begin
            n_err++; $display("FAIL tx_ovf_clear: got %h, want 00000006", d);
        end
    endtask

    task automatic test_rx_frame;
        bus_wr(5'h08, 32'd7, 4'h3);
        send_rx(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        bus_rd(5'h00, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 32'h13C) begin
            n_err++; $display("FAIL rx_byte_3c: got v=%b d=%h, want v=1 d=0000013c", v, d);
        end
        bus_rd(5'h00, d, v);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL rx_empty_read: got %h, want 00000000", d);
        end
    endtask

    task automatic test_rx_overrun;
        for (int i = 0; i < 17; i++) send_rx(8'h40 + 8'(i), 1'b1);
        repeat (4) @(negedge clk);
        bus_rd(5'h04, d, v);
        n_cmp++;
        if (d !== 32'h1A || irq !== 1'b1) begin
            n_err++; $display("FAIL rx_full_ovr: got status=%h irq=%b, want 0000001a irq=1", d, irq);
        end
        bus_wr(5'h04, 32'h10, 4'hF);
        bus_rd(5'h04, d, v);
        n_cmp++;
        if (d !== 32'h0A) begin
            n_err++; $display("FAIL rx_ovr_clear: got %h, want 0000000a", d);
        end
        for (int i = 0; i < 16; i++) begin
            bus_rd(5'h00, d, v);
            n_cmp++;
            if (d !== 32'h140 + 32'(i)) begin
                n_err++; $display("FAIL rx_order%0d: got %h, want %h", i, d, 32'h140 + 32'(i));
            end
        end
        bus_rd(5'h04, d, v);
        n_cmp++;
        if (d !== 32'h06) begin
            n_err++; $display("FAIL rx_drained_status: got %h, want 00000006", d);
        end
    endtask

    task automatic test_frame_err;
        send_rx(8'h55, 1'b0);
        repeat (16) @(negedge clk);
        bus_rd(5'h04, d, v);
        n_cmp++;
        if (d !== 32'h26) begin
            n_err++; $display("FAIL frm_err_status: got %h, want 00000026", d);
        end
        bus_rd(5'h00, d, v);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL frm_err_no_push: got %h, want 00000000", d);
        end
        bus_wr(5'h04, 32'h20, 4'hF);
        bus_rd(5'h04, d, v);
        n_cmp++;
        if (d !== 32'h06) begin
            n_err++; $display("FAIL frm_err_clear: got %h, want 00000006", d);
        end
    endtask

    task automatic test_div_byteenable;
        bus_wr(5'h08, 32'h0000_1234, 4'h2);
        bus_rd(5'h08, d, v);
        n_cmp++;
        if (d !== 32'h1207) begin
            n_err++; $display("FAIL div_lane1_only: got %h, want 00001207", d);
        end
        bus_rd(5'h1C, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 32'h0) begin
            n_err++; $display("FAIL unmapped_read: got v=%b d=%h, want v=1 d=00000000", v, d);
        end
    endtask

    task automatic test_reset_mid_tx;
        bit found;
        logic idle_ok;
        bus_wr(5'h08, 32'd3, 4'hF);
        bus_wr(5'h00, 32'h00, 4'h1);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (uart_txd === 1'b0) found = 1;
        end
        repeat (12) @(negedge clk);
        n_cmp++;
        if (!found || uart_txd !== 1'b0) begin
            n_err++; $display("FAIL midtx_line_low: got found=%b txd=%b, want found=1 txd=0", found, uart_txd);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (uart_txd !== 1'b1 || irq !== 1'b0) begin
            n_err++; $display("FAIL midtx_async_reset: got txd=%b irq=%b, want txd=1 irq=0", uart_txd, irq);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_rd(5'h04, d, v);
        n_cmp++;
        if (d !== 32'h06) begin
            n_err++; $display("FAIL midtx_status: got %h, want 00000006", d);
        end
        bus_rd(5'h08, d, v);
        n_cmp++;
        if (d !== 32'd433) begin
            n_err++; $display("FAIL midtx_div: got %0d, want 433", d);
        end
        idle_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin @(negedge clk); if (uart_txd !== 1'b1) idle_ok = 1'b0; end
        n_cmp++;
        if (idle_ok !== 1'b1) begin
            n_err++; $display("FAIL midtx_fifo_flushed: got txd activity, want idle high");
        end
    endtask

    initial begin
        test_reset;
        test_tx_frame;
        test_back_to_back;
        test_rx_frame;
        test_rx_overrun;
        test_frame_err;
        test_div_byteenable;
        test_reset_mid_tx;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
